uart_byte_tx: RTL and testbench

Serial transmitter for the SoC's byte-output channel: accepts the CPU-side `out_byte`/`out_byte_en` write strobe, buffers bytes, and serialises them as 8N1 UART frames on a single TX pin. It is the hardware consumer of the debug console stream, so firmware prints reach a host terminal on the FPGA board instead of only a simulation log. It sits between the `system` top-level byte port and the board's UART TX pad.

---
 rtl/uart_byte_tx.sv | 162 ++++++++++++++++
 tb/tb_uart_byte_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter for the CPU byte-output port, with a write buffer in front of the serialiser.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_byte_tx #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] out_byte,
    input  logic       out_byte_en,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);

    if (DIV < 2 || FIFO_DEPTH < 2) begin : g_param_chk
        $error("uart_byte_tx: requires DIV >= 2 and FIFO_DEPTH >= 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] baud;
    logic [2:0]    bitn;
    logic [7:0]    shift;

    logic       full;
    logic       empty;
    logic [7:0] head;
    logic       push;
    logic       pop;

    // A write during a full cycle is dropped even if a pop happens on the same edge.
    assign push  = out_byte_en && !full;
    assign pop   = (state == IDLE) && !empty;
    assign ready = !full;
    assign busy  = (state != IDLE) || !empty;

`ifdef UART_TX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    // Extra pointer MSB separates full from empty when the indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= out_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end
`else
    logic [7:0] hold;
    logic       hold_vld;

    assign empty = !hold_vld;
    assign full  = hold_vld;
    assign head  = hold;

    // push only happens when empty, so it never coincides with a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold     <= '0;
            hold_vld <= 1'b0;
        end else if (push) begin
            hold     <= out_byte;
            hold_vld <= 1'b1;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (out_byte_en && full) begin
            overflow <= 1'b1;
        end
    end

    // Frame FSM: tx is loaded one cycle ahead so each bit lasts exactly DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tx    <= 1'b1;
            baud  <= '0;
            bitn  <= '0;
            shift <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        shift <= head;
                        baud  <= '0;
                        bitn  <= '0;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud == CW'(DIV - 1)) begin
                        baud  <= '0;
                        tx    <= shift[0];
                        state <= DATA;
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                DATA: begin
                    if (baud == CW'(DIV - 1)) begin
                        baud <= '0;
                        if (bitn == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bitn  <= bitn + 3'd1;
                            tx    <= shift[1];
                            shift <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                STOP: begin
                    if (baud == CW'(DIV - 1)) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx: a timeline model predicts acceptance, pop edges and the
// expected line level each cycle; a monitor decodes frames from tx and checks them in order.
module tb_uart_byte_tx;

    localparam int unsigned CLK_HZ = 1000000;
    localparam int unsigned BAUD   = 100000;
    localparam int          DIV    = 10;
    localparam int          FRAME  = 10 * DIV;
`ifdef UART_TX_FIFO_EN
    localparam int          DEPTH  = 16;
`else
    localparam int          DEPTH  = 1;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] out_byte;
    logic       out_byte_en;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       overflow;

    uart_byte_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .out_byte(out_byte), .out_byte_en(out_byte_en),
        .ready(ready), .tx(tx), .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    typedef struct { int acc; int pop; logic [7:0] b; } frm_t;
    typedef struct { logic [7:0] b; int pop; } exp_t;

    frm_t frames[$];
    exp_t sb[$];
    int   last_pop = -1000;
    logic ovf_m    = 1'b0;
    int   gen      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
    endtask

    // A frame popped at edge p drives tx for edges p..p+FRAME-1; the FSM idles one cycle between frames.
    task automatic model_write(input int e, input logic [7:0] b);
        int occ = 0;
        int p;
        foreach (frames[i]) if (frames[i].acc <= e - 1 && frames[i].pop >= e) occ++;
        if (occ < DEPTH) begin
            p = (last_pop + FRAME + 1 > e + 1) ? last_pop + FRAME + 1 : e + 1;
            last_pop = p;
            frames.push_back('{acc: e, pop: p, b: b});
            sb.push_back('{b: b, pop: p});
        end else begin
            ovf_m = 1'b1;
        end
    endtask

    function automatic logic model_busy(input int l);
        logic r = 1'b0;
        foreach (frames[i]) if (frames[i].pop + FRAME > l) r = 1'b1;
        return r;
    endfunction

    task automatic check_cycle();
        int   l    = ecount;
        logic etx  = 1'b1;
        logic ebsy = 1'b0;
        int   occ  = 0;
        int   k;
        logic [7:0] fb;
        foreach (frames[i]) begin
            if (frames[i].pop <= l && l < frames[i].pop + FRAME) begin
                k    = (l - frames[i].pop) / DIV;
                fb   = frames[i].b;
                etx  = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : fb[k-1];
                ebsy = 1'b1;
            end
            if (frames[i].acc <= l && frames[i].pop > l) begin
                occ++;
                ebsy = 1'b1;
            end
        end
        chk("tx", 32'(tx), 32'(etx));
        chk("busy", 32'(busy), 32'(ebsy));
        chk("ready", 32'(ready), 32'(occ < DEPTH));
        chk("overflow", 32'(overflow), 32'(ovf_m));
    endtask

    // Drive one clock of stimulus from a negedge, then check the state after the edge.
    task automatic step(input logic en, input logic [7:0] b);
        out_byte_en = en;
        out_byte    = b;
        if (en) model_write(ecount + 1, b);
        @(negedge clk);
        out_byte_en = 1'b0;
        check_cycle();
    endtask

    task automatic idle_wait();
        int guard = 0;
        while (model_busy(ecount) && guard < 5000) begin
            step(1'b0, 8'h00);
            guard++;
        end
        if (guard >= 5000) chk("idle_timeout", 32'd1, 32'd0);
        repeat (3) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        frames.delete();
        sb.delete();
        ovf_m    = 1'b0;
        last_pop = -1000;
        gen++;
    endtask

    // Monitor: sample each bit at mid-cell and compare the decoded frame against the scoreboard.
    initial begin
        int   phase = 0;
        int   st    = 0;
        int   mg    = 0;
        int   off;
        logic [9:0] bits;
        exp_t e;
        bits = '0;
        forever begin
            @(negedge clk);
            if (rst || mg != gen) begin
                phase = 0;
                mg    = gen;
            end else if (phase == 0) begin
                if (tx === 1'b0) begin
                    phase = 1;
                    st    = ecount;
                    bits  = '0;
                end
            end else begin
                off = ecount - st;
                if (off % DIV == DIV / 2) bits[off / DIV] = tx;
                if (off == 9 * DIV + DIV / 2) begin
                    phase = 0;
                    if (sb.size() == 0) begin
                        chk("frame_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("frame_byte", 32'(bits[8:1]), 32'(e.b));
                        chk("frame_start_edge", 32'(st), 32'(e.pop));
                        chk("frame_start_bit", 32'(bits[0]), 32'd0);
                        chk("frame_stop_bit", 32'(bits[9]), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        int p;
        rst         = 1'b1;
        out_byte_en = 1'b0;
        out_byte    = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        repeat (3) step(1'b0, 8'h00);

        // single byte
        step(1'b1, 8'h55);
        idle_wait();

        // consecutive writes
        step(1'b1, 8'hA5);
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        idle_wait();

        // write landing on the edge the FSM pops a single queued entry
        step(1'b1, 8'($urandom));
        repeat (4) step(1'b0, 8'h00);
        step(1'b1, 8'($urandom));
        while (ecount < last_pop - 1) step(1'b0, 8'h00);
        step(1'b1, 8'($urandom));
        idle_wait();

        // burst of 17 while a frame is on the line
        step(1'b1, 8'($urandom));
        repeat (5) step(1'b0, 8'h00);
        for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom));
        idle_wait();

        // reset in the middle of data bit 3, then a fresh frame
        step(1'b1, 8'h3C);
        p = last_pop;
        while (ecount < p + 4 * DIV + DIV / 2) step(1'b0, 8'h00);
        do_reset();
        step(1'b0, 8'h00);
        step(1'b1, 8'h81);
        idle_wait();

        // random traffic
        for (int i = 0; i < 80; i++) step($urandom_range(0, 3) == 0, 8'($urandom));
        idle_wait();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
